// File: rtl/sdr_pkg.sv
// sdr_pkg: shared sample/stat widths and default FIFO depth for the SDR datapath
package sdr_pkg;
   localparam int SAMPLE_W   = 8;
   localparam int FIFO_DEPTH = 512;
   localparam int STAT_W     = 16;
   typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sample_fifo_if.sv
// sample_fifo_if: producer write port plus modulator read port of the sample FIFO
interface sample_fifo_if
   import sdr_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH,
   parameter int WIDTH = SAMPLE_W
);
   logic [WIDTH-1:0]         wr_data;
   logic                     wr_en;
   logic                     full;
   logic                     almost_full;
   logic                     read;
   logic [WIDTH-1:0]         sample;
   logic                     empty;
   logic [$clog2(DEPTH):0]   level;
   modport master (output wr_data, wr_en, read, input full, almost_full, sample, empty, level);
   modport slave  (input wr_data, wr_en, read, output full, almost_full, sample, empty, level);
endinterface

// File: rtl/sample_fifo_ram.sv
// fifo_ram: simple dual-port storage whose registered read port is the sample register
module fifo_ram #(
   parameter int DEPTH = 512,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   // storage array is never reset so it can map onto block RAM
   always_ff @(posedge clk)
      if (i_we) r_mem[i_waddr] <= i_wdata;
   // read register holds the head sample until the next accepted pop
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) o_rdata <= '0;
      else if (i_re) o_rdata <= r_mem[i_raddr];
endmodule

// File: rtl/sample_fifo.sv
// sample_fifo: host-to-modulator sample buffer with level/flags; SAMPLE_FIFO_STATS_EN adds drop counters
module sample_fifo
   import sdr_pkg::*;
#(
   parameter int DEPTH       = FIFO_DEPTH,
   parameter int WIDTH       = SAMPLE_W,
   parameter int AFULL_LEVEL = DEPTH - 64
) (
   input  logic              clk,
   input  logic              rst_n,
   sample_fifo_if.slave      bus,
   input  logic              i_stats_clr,
   output logic [STAT_W-1:0] o_overflow_cnt,
   output logic [STAT_W-1:0] o_underflow_cnt
);
   localparam int AW = $clog2(DEPTH);
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_level, w_level_nxt;
   logic          r_empty, r_full, r_afull;
   logic          w_wr, w_rd;
   assign w_wr        = bus.wr_en & ~r_full;
   assign w_rd        = bus.read & ~r_empty;
   assign w_level_nxt = r_level + (AW+1)'(w_wr) - (AW+1)'(w_rd);
   assign bus.level       = r_level;
   assign bus.empty       = r_empty;
   assign bus.full        = r_full;
   assign bus.almost_full = r_afull;
   // pointers advance only on accepted strobes; flags are registered from the next level
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_afull  <= 1'b0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level <= w_level_nxt;
         r_empty <= w_level_nxt == '0;
         r_full  <= w_level_nxt == (AW+1)'(DEPTH);
         r_afull <= w_level_nxt >= (AW+1)'(AFULL_LEVEL);
      end
   fifo_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_wr),
      .i_waddr (r_wr_ptr),
      .i_wdata (bus.wr_data),
      .i_re    (w_rd),
      .i_raddr (r_rd_ptr),
      .o_rdata (bus.sample)
   );
`ifdef SAMPLE_FIFO_STATS_EN
   logic [STAT_W-1:0] r_ovf_cnt, r_udf_cnt;
   // saturating drop counters; a clear wins over a same-cycle increment
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_ovf_cnt <= '0;
         r_udf_cnt <= '0;
      end else if (i_stats_clr) begin
         r_ovf_cnt <= '0;
         r_udf_cnt <= '0;
      end else begin
         if (bus.wr_en & r_full & ~&r_ovf_cnt) r_ovf_cnt <= r_ovf_cnt + 1'b1;
         if (bus.read & r_empty & ~&r_udf_cnt) r_udf_cnt <= r_udf_cnt + 1'b1;
      end
   assign o_overflow_cnt  = r_ovf_cnt;
   assign o_underflow_cnt = r_udf_cnt;
`else
   logic w_unused_stats_clr;
   assign w_unused_stats_clr = i_stats_clr;
   assign o_overflow_cnt     = '0;
   assign o_underflow_cnt    = '0;
`endif
endmodule

// File: tb/tb_sample_fifo.sv
// tb_sample_fifo: randomized bench for sample_fifo against a queue-based reference model
module tb_sample_fifo;
   import sdr_pkg::*;
   localparam int DEPTH = 8;
   localparam int AFULL = 6;
`ifdef SAMPLE_FIFO_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   logic clk, rst_n, stats_clr;
   logic [15:0] ovf, udf;
   sample_fifo_if #(.DEPTH(DEPTH), .WIDTH(SAMPLE_W)) f ();
   sample_fifo #(.DEPTH(DEPTH), .WIDTH(SAMPLE_W), .AFULL_LEVEL(AFULL)) dut (
      .clk(clk), .rst_n(rst_n), .bus(f), .i_stats_clr(stats_clr),
      .o_overflow_cnt(ovf), .o_underflow_cnt(udf)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   sample_t q[$];
   sample_t exp_sample = '0;
   int exp_ovf = 0, exp_udf = 0;

   task automatic model_reset();
      q.delete();
      exp_sample = '0;
      exp_ovf = 0;
      exp_udf = 0;
   endtask

   task automatic step(input bit wr, input sample_t d, input bit rd, input bit clr);
      int sz;
      f.wr_en = wr; f.wr_data = d; f.read = rd; stats_clr = clr;
      @(posedge clk);
      sz = q.size();
      if (STATS) begin
         if (clr) begin exp_ovf = 0; exp_udf = 0; end
         else begin
            if (wr && sz == DEPTH && exp_ovf < 65535) exp_ovf++;
            if (rd && sz == 0 && exp_udf < 65535) exp_udf++;
         end
      end
      if (rd && sz > 0) exp_sample = q.pop_front();
      if (wr && sz < DEPTH) q.push_back(d);
      #1;
      f.wr_en = 1'b0; f.read = 1'b0; stats_clr = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++; if ({f.empty, f.full, f.almost_full} !== 3'b100) begin n_bad++; $display("FAIL reset_flags got %b exp 100", {f.empty, f.full, f.almost_full}); end
      n_cmp++; if (f.level !== 4'd0) begin n_bad++; $display("FAIL reset_level got %0d exp 0", f.level); end
      n_cmp++; if (f.sample !== 8'h00) begin n_bad++; $display("FAIL reset_sample got %h exp 00", f.sample); end
      n_cmp++; if ({ovf, udf} !== 32'h0) begin n_bad++; $display("FAIL reset_cnt got %h/%h exp 0/0", ovf, udf); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      step(0, 8'h00, 1, 0);
      n_cmp++; if (f.sample !== 8'h00) begin n_bad++; $display("FAIL udf_sample got %h exp 00", f.sample); end
      n_cmp++; if (udf !== (STATS ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL udf_cnt got %0d exp %0d", udf, STATS ? 1 : 0); end
      n_cmp++; if (f.empty !== 1'b1) begin n_bad++; $display("FAIL udf_empty got %b exp 1", f.empty); end
   endtask

   task automatic test_basic();
      sample_t vals [3] = '{8'h11, 8'h22, 8'h33};
      foreach (vals[i]) step(1, vals[i], 0, 0);
      n_cmp++; if (f.level !== 4'd3 || f.empty !== 1'b0) begin n_bad++; $display("FAIL basic_fill got lvl=%0d empty=%b exp lvl=3 empty=0", f.level, f.empty); end
      foreach (vals[i]) begin
         step(0, 8'h00, 1, 0);
         n_cmp++; if (f.sample !== vals[i]) begin n_bad++; $display("FAIL basic_rd%0d got %h exp %h", i, f.sample, vals[i]); end
         n_cmp++; if (f.level !== 4'(2 - i)) begin n_bad++; $display("FAIL basic_lvl%0d got %0d exp %0d", i, f.level, 2 - i); end
      end
      n_cmp++; if (f.empty !== 1'b1) begin n_bad++; $display("FAIL basic_empty got %b exp 1", f.empty); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 10; i++) begin
         step(1, sample_t'($urandom), 0, 0);
         n_cmp++; if (f.almost_full !== (q.size() >= AFULL) || f.full !== (q.size() == DEPTH)) begin
            n_bad++; $display("FAIL full_flags%0d got af=%b f=%b exp af=%b f=%b", i, f.almost_full, f.full, q.size() >= AFULL, q.size() == DEPTH); end
      end
      n_cmp++; if (f.level !== 4'd8) begin n_bad++; $display("FAIL full_level got %0d exp 8", f.level); end
      n_cmp++; if (ovf !== 16'(exp_ovf)) begin n_bad++; $display("FAIL full_ovf got %0d exp %0d", ovf, exp_ovf); end
      for (int i = 0; i < 8; i++) begin
         step(0, 8'h00, 1, 0);
         n_cmp++; if (f.sample !== exp_sample) begin n_bad++; $display("FAIL full_rd%0d got %h exp %h", i, f.sample, exp_sample); end
      end
      n_cmp++; if (f.empty !== 1'b1 || f.level !== 4'd0) begin n_bad++; $display("FAIL full_drain got empty=%b lvl=%0d exp 1/0", f.empty, f.level); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) step(1, sample_t'($urandom), 0, 0);
      for (int i = 0; i < 20; i++) begin
         step(1, sample_t'($urandom), 1, 0);
         n_cmp++; if (f.level !== 4'd4) begin n_bad++; $display("FAIL wrap_lvl%0d got %0d exp 4", i, f.level); end
         n_cmp++; if (f.sample !== exp_sample) begin n_bad++; $display("FAIL wrap_rd%0d got %h exp %h", i, f.sample, exp_sample); end
      end
   endtask

   task automatic test_full_rdwr();
      while (q.size() < DEPTH) step(1, sample_t'($urandom), 0, 0);
      step(1, 8'hA5, 1, 0);
      n_cmp++; if (f.level !== 4'(DEPTH - 1)) begin n_bad++; $display("FAIL frw_level got %0d exp %0d", f.level, DEPTH - 1); end
      n_cmp++; if (f.sample !== exp_sample) begin n_bad++; $display("FAIL frw_sample got %h exp %h", f.sample, exp_sample); end
      n_cmp++; if (ovf !== 16'(exp_ovf)) begin n_bad++; $display("FAIL frw_ovf got %0d exp %0d", ovf, exp_ovf); end
      while (q.size() > 0) begin
         step(0, 8'h00, 1, 0);
         n_cmp++; if (f.sample !== exp_sample) begin n_bad++; $display("FAIL frw_drain got %h exp %h", f.sample, exp_sample); end
      end
   endtask

   task automatic test_stats_clr();
      step(1, 8'h01, 1, 1);
      n_cmp++; if ({ovf, udf} !== 32'h0) begin n_bad++; $display("FAIL clr_cnt got %0d/%0d exp 0/0", ovf, udf); end
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 1, 0);
      n_cmp++; if (udf !== 16'(exp_udf)) begin n_bad++; $display("FAIL clr_udf got %0d exp %0d", udf, exp_udf); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 99) < 60), sample_t'($urandom), 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 3));
         n_cmp++; if (f.level !== 4'(q.size()) || f.empty !== (q.size() == 0) || f.full !== (q.size() == DEPTH) || f.almost_full !== (q.size() >= AFULL)) begin
            n_bad++; $display("FAIL rnd_state%0d got lvl=%0d e=%b f=%b af=%b exp lvl=%0d", i, f.level, f.empty, f.full, f.almost_full, q.size()); end
         n_cmp++; if (f.sample !== exp_sample) begin n_bad++; $display("FAIL rnd_sample%0d got %h exp %h", i, f.sample, exp_sample); end
         n_cmp++; if (ovf !== 16'(exp_ovf) || udf !== 16'(exp_udf)) begin n_bad++; $display("FAIL rnd_cnt%0d got %0d/%0d exp %0d/%0d", i, ovf, udf, exp_ovf, exp_udf); end
      end
   endtask

   task automatic test_rst_mid();
      sample_t d;
      while (q.size() > 5) step(0, 8'h00, 1, 0);
      while (q.size() < 5) step(1, sample_t'($urandom), 0, 0);
      step(0, 8'h00, 1, 0);
      step(1, sample_t'($urandom), 0, 0);
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({f.empty, f.full, f.almost_full} !== 3'b100 || f.level !== 4'd0) begin n_bad++; $display("FAIL mid_rst_state got e=%b f=%b af=%b lvl=%0d exp 1/0/0/0", f.empty, f.full, f.almost_full, f.level); end
      n_cmp++; if (f.sample !== 8'h00 || {ovf, udf} !== 32'h0) begin n_bad++; $display("FAIL mid_rst_out got %h %0d/%0d exp 00 0/0", f.sample, ovf, udf); end
      model_reset();
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      d = sample_t'($urandom_range(1, 255));
      step(1, d, 0, 0);
      step(0, 8'h00, 1, 0);
      n_cmp++; if (f.sample !== d) begin n_bad++; $display("FAIL mid_rst_rd got %h exp %h", f.sample, d); end
      n_cmp++; if (f.empty !== 1'b1) begin n_bad++; $display("FAIL mid_rst_empty got %b exp 1", f.empty); end
   endtask

   initial begin
      rst_n = 1'b0; stats_clr = 1'b0;
      f.wr_en = 1'b0; f.read = 1'b0; f.wr_data = '0;
      model_reset();
      test_reset();
      test_basic();
      test_full();
      test_wrap();
      test_full_rdwr();
      test_stats_clr();
      test_random();
      test_rst_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
